// File: rtl/iobus_uart_tx_if.sv
// OTTER IOBUS MMIO port plus serial line for the UART transmitter.
// TX_INTR exists only when UART_TX_INTR_EN is defined.
interface iobus_uart_tx_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_RD_DATA;
  logic        TX;
  logic        TX_ACTIVE;
`ifdef UART_TX_INTR_EN
  logic        TX_INTR;

  modport master (output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
                  input  IOBUS_RD_DATA, TX, TX_ACTIVE, TX_INTR);
  modport slave  (input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
                  output IOBUS_RD_DATA, TX, TX_ACTIVE, TX_INTR);
`else
  modport master (output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
                  input  IOBUS_RD_DATA, TX, TX_ACTIVE);
  modport slave  (input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
                  output IOBUS_RD_DATA, TX, TX_ACTIVE);
`endif
endinterface

// File: rtl/iobus_uart_tx.sv
// MMIO UART transmitter: TX FIFO behind a data register, 8N1 LSB-first serializer.
// Define UART_TX_INTR_EN to add a one-cycle TX_INTR pulse when the line goes idle.
module iobus_uart_tx #(
  parameter int          CLK_RATE   = 50,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h11000040
) (
  input  logic           CLK,
  input  logic           RESET,
  iobus_uart_tx_if.slave bus
);

  localparam int DIV = (CLK_RATE * 1_000_000 + BAUD / 2) / BAUD;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          full, empty, push_req, clr_req, push, pop;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d, active_q, active_d;
  logic          unused_hi;
`ifdef UART_TX_INTR_EN
  logic          intr_q, intr_d;
`endif

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push_req  = bus.IOBUS_WR && (bus.IOBUS_ADDR == BASE_ADDR);
  assign clr_req   = bus.IOBUS_WR && (bus.IOBUS_ADDR == STAT_ADDR);
  // A full FIFO still accepts a byte when the serializer pops in the same cycle.
  assign push      = push_req && (!full || pop);
  assign unused_hi = ^bus.IOBUS_OUT[31:8];

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    active_d = active_q;
    pop      = 1'b0;
`ifdef UART_TX_INTR_EN
    intr_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d     = 1'b1;
        active_d = 1'b0;
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = mem[rd_ptr];
          baud_d   = BW'(DIV - 1);
          tx_d     = 1'b0;
          active_d = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else begin
          baud_d  = BW'(DIV - 1);
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else begin
          baud_d = BW'(DIV - 1);
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else if (!empty) begin
          // Next frame starts straight out of the stop bit, no idle gap.
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = BW'(DIV - 1);
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          active_d = 1'b0;
          state_d  = IDLE;
`ifdef UART_TX_INTR_EN
          intr_d   = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
`ifdef UART_TX_INTR_EN
      intr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      active_q <= active_d;
`ifdef UART_TX_INTR_EN
      intr_q   <= intr_d;
`endif
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (clr_req)
        ovf <= 1'b0;
      else if (push_req && full && !pop)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && push) mem[wr_ptr] <= bus.IOBUS_OUT[7:0];
  end

  always_comb begin
    bus.IOBUS_RD_DATA = '0;
    if (bus.IOBUS_ADDR == STAT_ADDR) begin
      bus.IOBUS_RD_DATA[0]    = full;
      bus.IOBUS_RD_DATA[1]    = empty;
      bus.IOBUS_RD_DATA[2]    = active_q;
      bus.IOBUS_RD_DATA[3]    = ovf;
      bus.IOBUS_RD_DATA[16:8] = 9'(count);
    end
  end

  assign bus.TX        = tx_q;
  assign bus.TX_ACTIVE = active_q;
`ifdef UART_TX_INTR_EN
  assign bus.TX_INTR   = intr_q;
`endif

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Self-checking bench for iobus_uart_tx at default parameters (DIV = 434).
module tb_iobus_uart_tx;

  localparam int          DIV    = 434;
  localparam logic [31:0] DATA_A = 32'h11000040;
  localparam logic [31:0] STAT_A = 32'h11000044;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_status;
  } vec_t;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   intr_cnt = 0;

  iobus_uart_tx_if bus ();

  iobus_uart_tx dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

`ifdef UART_TX_INTR_EN
  always @(posedge CLK) if (bus.TX_INTR === 1'b1) intr_cnt++;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus();
    bus.IOBUS_WR   = 1'b0;
    bus.IOBUS_ADDR = 32'h0;
    bus.IOBUS_OUT  = 32'h0;
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data);
    bus.IOBUS_WR   = 1'b1;
    bus.IOBUS_ADDR = addr;
    bus.IOBUS_OUT  = data;
    tick();
    idle_bus();
  endtask

  task automatic read_status(output logic [31:0] v);
    bus.IOBUS_ADDR = STAT_A;
    #1;
    v = bus.IOBUS_RD_DATA;
    bus.IOBUS_ADDR = 32'h0;
  endtask

  task automatic do_reset();
    idle_bus();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  // Waits (bounded) for the start bit, then checks every cycle of the 10-bit frame.
  task automatic check_frame(input logic [7:0] data, input int max_wait,
                             input logic [31:0] mid_status, input string name,
                             output int waited);
    int          bad;
    int          act_bad;
    int          b;
    logic        expbit;
    logic [31:0] s;
    waited = 0;
    while (bus.TX !== 1'b0 && waited < max_wait) begin
      tick();
      waited++;
    end
    if (bus.TX !== 1'b0) begin
      check({name, " start bit timeout"}, 32'(bus.TX), 32'h0);
      return;
    end
    bad = 0;
    act_bad = 0;
    for (int j = 0; j < 10 * DIV; j++) begin
      b = j / DIV;
      if (b == 0)      expbit = 1'b0;
      else if (b == 9) expbit = 1'b1;
      else             expbit = data[b-1];
      if (bus.TX !== expbit) bad++;
      if (bus.TX_ACTIVE !== 1'b1) act_bad++;
      if (j == 1000) begin
        read_status(s);
        check({name, " mid-frame status"}, s, mid_status);
      end
      tick();
    end
    check({name, " bad tx cycles"}, 32'(bad), 32'h0);
    check({name, " inactive cycles"}, 32'(act_bad), 32'h0);
  endtask

  initial begin
    vec_t        vecs[21];
    logic [31:0] s;
    int          w;
    int          lows;
    int          acts;

    idle_bus();
    RESET = 1'b1;
    tick();
    tick();
    check("reset tx", 32'(bus.TX), 32'h1);
    check("reset tx_active", 32'(bus.TX_ACTIVE), 32'h0);
    read_status(s);
    check("reset status", s, 32'h0000_0002);
`ifdef UART_TX_INTR_EN
    check("reset tx_intr", 32'(bus.TX_INTR), 32'h0);
`endif
    RESET = 1'b0;
    bus.IOBUS_ADDR = DATA_A;
    #1;
    check("data reg reads zero", bus.IOBUS_RD_DATA, 32'h0);
    idle_bus();
    tick();

    // 1: single 0x55 frame, pop one edge after the push
    intr_cnt = 0;
    write(DATA_A, 32'h55);
    check_frame(8'h55, 5, 32'h0000_0006, "t1", w);
    check("t1 push-to-start latency", 32'(w), 32'h1);
    check("t1 idle tx", 32'(bus.TX), 32'h1);
    check("t1 idle tx_active", 32'(bus.TX_ACTIVE), 32'h0);
`ifdef UART_TX_INTR_EN
    check("t1 tx_intr on idle entry", 32'(bus.TX_INTR), 32'h1);
    tick();
    check("t1 tx_intr drops", 32'(bus.TX_INTR), 32'h0);
    check("t1 tx_intr pulses", 32'(intr_cnt), 32'h1);
`endif

    // 2: upper data bits ignored
    write(DATA_A, 32'h0000_01A5);
    check_frame(8'hA5, 5, 32'h0000_0006, "t2", w);
    check("t2 idle tx_active", 32'(bus.TX_ACTIVE), 32'h0);

    // 4: back-to-back frames, push and pop in the same cycle
    intr_cnt = 0;
    write(DATA_A, 32'h41);
    write(DATA_A, 32'h42);
    check_frame(8'h41, 5, 32'h0000_0104, "t4a", w);
    check_frame(8'h42, 0, 32'h0000_0006, "t4b", w);
    check("t4 no gap", 32'(w), 32'h0);
    check("t4 idle tx_active", 32'(bus.TX_ACTIVE), 32'h0);
`ifdef UART_TX_INTR_EN
    tick();
    check("t4 single tx_intr", 32'(intr_cnt), 32'h1);
`endif

    // 3: fill, overflow, clear, ignored addresses
    do_reset();
    for (int i = 0; i < 17; i++) begin
      vecs[i].wr         = 1'b1;
      vecs[i].addr       = DATA_A;
      vecs[i].wdata      = 32'(i);
      vecs[i].exp_status = (i == 0)  ? 32'h0000_0100 :
                           (i == 16) ? 32'h0000_1005 : ((32'(i) << 8) | 32'h4);
    end
    vecs[17] = '{1'b1, DATA_A,        32'h11, 32'h0000_100D};
    vecs[18] = '{1'b1, 32'h11000048,  32'h0,  32'h0000_100D};
    vecs[19] = '{1'b1, STAT_A,        32'h0,  32'h0000_1005};
    vecs[20] = '{1'b0, DATA_A,        32'h77, 32'h0000_1005};
    for (int i = 0; i < 21; i++) begin
      bus.IOBUS_WR   = vecs[i].wr;
      bus.IOBUS_ADDR = vecs[i].addr;
      bus.IOBUS_OUT  = vecs[i].wdata;
      tick();
      idle_bus();
      read_status(s);
      check($sformatf("t3 vec%0d status", i), s, vecs[i].exp_status);
    end

    // 5: reset mid-frame with bytes queued
    do_reset();
    write(DATA_A, 32'h10);
    write(DATA_A, 32'h20);
    write(DATA_A, 32'h30);
    w = 0;
    while (bus.TX !== 1'b0 && w < 5) begin
      tick();
      w++;
    end
    check("t5 frame started", 32'(bus.TX), 32'h0);
    for (int i = 0; i < 2000; i++) tick();
    RESET = 1'b1;
    tick();
    check("t5 tx after reset", 32'(bus.TX), 32'h1);
    check("t5 active after reset", 32'(bus.TX_ACTIVE), 32'h0);
    read_status(s);
    check("t5 status after reset", s, 32'h0000_0002);
    RESET = 1'b0;
    lows = 0;
    acts = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (bus.TX !== 1'b1) lows++;
      if (bus.TX_ACTIVE !== 1'b0) acts++;
    end
    check("t5 no further frames", 32'(lows), 32'h0);
    check("t5 stays inactive", 32'(acts), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
